// File: rtl/divide_prog.sv
// divide_prog: multi-channel, run-time programmable integer clock divider.
//
// Each channel divides clk by its own divisor: 0 = off (held low), 1 = bypass (clkout = clk),
// 2..2^WIDTH-1 = divide. Odd divisors keep a 50% duty by ANDing the posedge-generated phase
// with a copy of it resampled on the falling edge. New divisors arrive over a valid/ready port
// into a per-channel shadow register and are applied only at the channel's period boundary.
//
// Optional feature: define DIVIDE_PROG_SYNC_EN to add the 'sync' input. A posedge with sync=1
// restarts every running channel (cnt=0, clk_p=0), phase-aligning them; tick is suppressed for
// that cycle, and a pending update is applied at the forced restart.
//
// Ports:
//   clk        in   system clock, both edges used
//   rst        in   asynchronous reset, active-high
//   cfg_valid  in   divisor update request
//   cfg_ready  out  update can be accepted this cycle (combinational from cfg_ch)
//   cfg_ch     in   target channel; channels >= CHANNELS are accepted and dropped
//   cfg_div    in   new divisor
//   sync       in   (DIVIDE_PROG_SYNC_EN only) restart all running channels
//   clkout     out  divided clocks, one bit per channel
//   tick       out  one-clk pulse per output period, usable as a clock enable

module divide_prog #(
    parameter int unsigned  CHANNELS    = 4,
    parameter int unsigned  WIDTH       = 8,
    parameter int unsigned  DEFAULT_DIV = 12,
    localparam int unsigned CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [WIDTH-1:0]    cfg_div,
`ifdef DIVIDE_PROG_SYNC_EN
    input  logic                sync,
`endif
    output logic [CHANNELS-1:0] clkout,
    output logic [CHANNELS-1:0] tick
);

    logic                sync_req;
    logic [CHANNELS-1:0] pending;

`ifdef DIVIDE_PROG_SYNC_EN
    assign sync_req = sync;
`else
    assign sync_req = 1'b0;
`endif

    // Out-of-range channels never match, so they see ready=1 and the write is dropped.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = !pending[i];
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [WIDTH-1:0] cnt_q, cnt_d;
        logic [WIDTH-1:0] div_q, div_d;
        logic [WIDTH-1:0] shadow_q, shadow_d;
        logic             pend_q, pend_d;
        logic             clk_p_q, clk_p_d;
        logic             clk_n_q;
        logic             tick_q, tick_d;
        logic             run, last, restart, bnd, wr;

        assign run     = (div_q >= WIDTH'(2));
        assign last    = run && (cnt_q == div_q - WIDTH'(1));
        assign restart = run && sync_req;
        // Off/bypass channels sit on a boundary every cycle.
        assign bnd     = !run || last || restart;
        assign wr      = cfg_valid && cfg_ready && (cfg_ch == CH_W'(g));

        always_comb begin
            cnt_d    = cnt_q;
            div_d    = div_q;
            shadow_d = shadow_q;
            pend_d   = pend_q;
            if (pend_q && bnd) begin
                div_d  = shadow_q;
                cnt_d  = '0;
                pend_d = 1'b0;
            end else if (bnd) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
            // A transfer is only possible while pend_q is clear, so it never races the apply.
            if (wr) begin
                shadow_d = cfg_div;
                pend_d   = 1'b1;
            end
            // clk_p tracks the count it is registered alongside: high for the upper half.
            clk_p_d = (div_d >= WIDTH'(2)) && (cnt_d >= (div_d >> 1));
            if (restart) begin
                tick_d = 1'b0;
            end else if (div_q == WIDTH'(1)) begin
                tick_d = 1'b1;
            end else begin
                tick_d = last;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q    <= '0;
                div_q    <= WIDTH'(DEFAULT_DIV);
                shadow_q <= '0;
                pend_q   <= 1'b0;
                clk_p_q  <= 1'b0;
                tick_q   <= 1'b0;
            end else begin
                cnt_q    <= cnt_d;
                div_q    <= div_d;
                shadow_q <= shadow_d;
                pend_q   <= pend_d;
                clk_p_q  <= clk_p_d;
                tick_q   <= tick_d;
            end
        end

        // Half-cycle delayed phase; ANDing it trims the odd-divisor high time by half a clk.
        always_ff @(negedge clk or posedge rst) begin
            if (rst) begin
                clk_n_q <= 1'b0;
            end else begin
                clk_n_q <= clk_p_q;
            end
        end

        always_comb begin
            if (div_q == '0) begin
                clkout[g] = 1'b0;
            end else if (div_q == WIDTH'(1)) begin
                clkout[g] = clk;
            end else if (div_q[0]) begin
                clkout[g] = clk_p_q & clk_n_q;
            end else begin
                clkout[g] = clk_p_q;
            end
        end

        assign pending[g] = pend_q;
        assign tick[g]    = tick_q;
    end

endmodule
